// File: rtl/axi_dma_pkg.sv
// Shared types for the AXI DMA read command sequencer.
// Optional 4 KiB splitting: AXI_DMA_RD_CMD_SEQ_SPLIT_4K_EN.
package axi_dma_pkg;

  localparam int DESC_AW = 64;
  localparam int DESC_RW = 16;
  localparam int AXI_4K_BOUNDARY = 4096;

  typedef struct packed {
    logic [DESC_AW-1:0] base;
    logic [31:0]        row_bytes;
    logic [DESC_RW-1:0] rows;
    logic [31:0]        stride;
  } dma_rd_desc_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } seq_state_e;

endpackage

// File: rtl/axi_dma_rd_cmd_split.sv
// Clips a read piece so it never crosses a 4 KiB boundary.
// Used only when AXI_DMA_RD_CMD_SEQ_SPLIT_4K_EN is defined.
module axi_dma_rd_cmd_split
  import axi_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
)(
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           rem_i,
  output logic [31:0]           len_o,
  output logic [ADDR_WIDTH-1:0] next_addr_o
);

  logic [12:0] room;

  assign room = 13'(AXI_4K_BOUNDARY) - {1'b0, addr_i[11:0]};
  assign len_o = (rem_i > {19'd0, room}) ? {19'd0, room} : rem_i;
  assign next_addr_o = addr_i + ADDR_WIDTH'(len_o);

endmodule

// File: rtl/axi_dma_rd_cmd_seq.sv
// Expands a 2D strided tile descriptor into DMA row read commands.
// Define AXI_DMA_RD_CMD_SEQ_SPLIT_4K_EN to split rows at 4 KiB.
module axi_dma_rd_cmd_seq
  import axi_dma_pkg::*;
#(
  parameter int ADDR_WIDTH      = 64,
  parameter int ROWS_WIDTH      = 16,
  parameter int MAX_OUTSTANDING = 4
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [ADDR_WIDTH-1:0] desc_base,
  input  logic [31:0]           desc_row_bytes,
  input  logic [ROWS_WIDTH-1:0] desc_rows,
  input  logic [31:0]           desc_stride,
  output logic                  init_read,
  output logic [ADDR_WIDTH-1:0] axi_start_addr,
  output logic [31:0]           axi_byte_length,
  input  logic                  axi_start_ready,
  input  logic                  axi_idle,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           cmd_count
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  seq_state_e            state_q, state_d;
  dma_rd_desc_t          in_desc;
  logic [ROWS_WIDTH-1:0] rows_q, rows_d, row_q, row_d;
  logic [31:0]           rbytes_q, rbytes_d, stride_q, stride_d;
  logic [31:0]           rem_q, rem_d, len_q, len_d, cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] row_addr_q, row_addr_d, addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] end_q, end_d;
  logic [OW-1:0]         out_q, out_d;
  logic                  init_q, init_d, rdy_q, rdy_d;
  logic                  err_q, err_d, arm_q, arm_d;
  logic                  hs, xfer, row_end, last, can_issue;
  logic [ADDR_WIDTH-1:0] nx_addr, nx_end;
  logic [31:0]           nx_rem, nx_len;

  assign in_desc = '{
    base:      DESC_AW'(desc_base),
    row_bytes: desc_row_bytes,
    rows:      DESC_RW'(desc_rows),
    stride:    desc_stride
  };

  assign hs      = desc_valid && rdy_q;
  assign xfer    = init_q && axi_start_ready;
  assign row_end = len_q == rem_q;
  assign last    = row_end && (row_q == rows_q - ROWS_WIDTH'(1));

  // Conservative throttle: any idle cycle without a transfer empties it.
  assign out_d = xfer ? out_q + OW'(1) : (axi_idle ? '0 : out_q);
  assign can_issue = out_d < OW'(MAX_OUTSTANDING);

  always_comb begin
    nx_addr = end_q;
    nx_rem  = rem_q - len_q;
    if (state_q == IDLE) begin
      nx_addr = ADDR_WIDTH'(in_desc.base);
      nx_rem  = in_desc.row_bytes;
    end else if (row_end) begin
      nx_addr = row_addr_q + ADDR_WIDTH'(stride_q);
      nx_rem  = rbytes_q;
    end
  end

`ifdef AXI_DMA_RD_CMD_SEQ_SPLIT_4K_EN
  axi_dma_rd_cmd_split #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_split (
    .addr_i     (nx_addr),
    .rem_i      (nx_rem),
    .len_o      (nx_len),
    .next_addr_o(nx_end)
  );
`else
  assign nx_len = nx_rem;
  assign nx_end = nx_addr + ADDR_WIDTH'(nx_rem);
`endif

  always_comb begin
    state_d    = state_q;
    rows_d     = rows_q;
    row_d      = row_q;
    rbytes_d   = rbytes_q;
    stride_d   = stride_q;
    rem_d      = rem_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    row_addr_d = row_addr_q;
    addr_d     = addr_q;
    end_d      = end_q;
    init_d     = init_q;
    arm_d      = arm_q;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          if (in_desc.rows == '0 || in_desc.row_bytes == '0) begin
            err_d = 1'b1;
          end else begin
            state_d    = ISSUE;
            rows_d     = ROWS_WIDTH'(in_desc.rows);
            rbytes_d   = in_desc.row_bytes;
            stride_d   = in_desc.stride;
            row_d      = '0;
            row_addr_d = nx_addr;
            addr_d     = nx_addr;
            rem_d      = nx_rem;
            len_d      = nx_len;
            end_d      = nx_end;
          end
        end
      end
      ISSUE: begin
        if (xfer) begin
          cnt_d = cnt_q + 32'd1;
          if (last) begin
            init_d  = 1'b0;
            arm_d   = 1'b0;
            state_d = DRAIN;
          end else begin
            if (row_end) begin
              row_d      = row_q + ROWS_WIDTH'(1);
              row_addr_d = nx_addr;
            end
            addr_d = nx_addr;
            rem_d  = nx_rem;
            len_d  = nx_len;
            end_d  = nx_end;
            init_d = can_issue;
          end
        end else if (!init_q) begin
          init_d = can_issue;
        end
      end
      DRAIN: begin
        // Idle is trusted only from the second cycle after the last command.
        arm_d = 1'b1;
        if (arm_q && axi_idle) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rdy_d = state_d == IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rows_q     <= '0;
      row_q      <= '0;
      rbytes_q   <= '0;
      stride_q   <= '0;
      rem_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      row_addr_q <= '0;
      addr_q     <= '0;
      end_q      <= '0;
      out_q      <= '0;
      init_q     <= 1'b0;
      rdy_q      <= 1'b0;
      err_q      <= 1'b0;
      arm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      row_q      <= row_d;
      rbytes_q   <= rbytes_d;
      stride_q   <= stride_d;
      rem_q      <= rem_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      row_addr_q <= row_addr_d;
      addr_q     <= addr_d;
      end_q      <= end_d;
      out_q      <= out_d;
      init_q     <= init_d;
      rdy_q      <= rdy_d;
      err_q      <= err_d;
      arm_q      <= arm_d;
    end
  end

  assign desc_ready      = rdy_q;
  assign init_read       = init_q;
  assign axi_start_addr  = addr_q;
  assign axi_byte_length = len_q;
  assign busy            = (state_q == ISSUE) || (state_q == DRAIN);
  assign done            = state_q == DONE;
  assign err             = err_q;
  assign cmd_count       = cnt_q;

endmodule

// File: tb/tb_axi_dma_rd_cmd_seq.sv
// Randomised bench for axi_dma_rd_cmd_seq against a command-list model.
// Honours AXI_DMA_RD_CMD_SEQ_SPLIT_4K_EN when defined.
module tb_axi_dma_rd_cmd_seq;

  localparam int MO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        desc_valid = 1'b0;
  logic        desc_ready;
  logic [63:0] desc_base = '0;
  logic [31:0] desc_row_bytes = '0;
  logic [15:0] desc_rows = '0;
  logic [31:0] desc_stride = '0;
  logic        init_read;
  logic [63:0] axi_start_addr;
  logic [31:0] axi_byte_length;
  logic        axi_start_ready = 1'b1;
  logic        axi_idle = 1'b1;
  logic        busy, done, err;
  logic [31:0] cmd_count;

  typedef struct {
    logic [63:0] a;
    logic [31:0] l;
  } cmd_t;

  cmd_t        exp_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          last_cyc = 0;
  int          first_ok = 0;
  int          xfers = 0;
  int          x0 = 0;
  int          ndone = 0;
  int          out_m = 0;
  bit          armed = 1'b0;
  bit          consec = 1'b0;
  logic [31:0] exp_total = '0;

  always #5 clk = ~clk;

  axi_dma_rd_cmd_seq #(
    .ADDR_WIDTH(64),
    .ROWS_WIDTH(16),
    .MAX_OUTSTANDING(MO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .desc_valid     (desc_valid),
    .desc_ready     (desc_ready),
    .desc_base      (desc_base),
    .desc_row_bytes (desc_row_bytes),
    .desc_rows      (desc_rows),
    .desc_stride    (desc_stride),
    .init_read      (init_read),
    .axi_start_addr (axi_start_addr),
    .axi_byte_length(axi_byte_length),
    .axi_start_ready(axi_start_ready),
    .axi_idle       (axi_idle),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .cmd_count      (cmd_count)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
  endtask

  // Reference: list every command a descriptor must produce, in order.
  task automatic expect_desc(input logic [63:0] b, input logic [31:0] rb,
                             input int rows, input logic [31:0] st);
    for (int r = 0; r < rows; r++) begin
      logic [63:0] a;
      logic [31:0] rem;
      logic [31:0] l;
      a = b + 64'(r) * {32'd0, st};
      rem = rb;
      while (rem != 0) begin
`ifdef AXI_DMA_RD_CMD_SEQ_SPLIT_4K_EN
        l = 32'd4096 - {20'd0, a[11:0]};
        if (l > rem) l = rem;
`else
        l = rem;
`endif
        exp_q.push_back('{a, l});
        exp_total++;
        a += {32'd0, l};
        rem -= l;
      end
    end
  endtask

  always @(negedge clk) begin
    cmd_t c;
    cyc++;
    if (rst) begin
      out_m = 0;
    end else begin
      if (done) begin
        ndone++;
        chk("done_time", 64'(cyc), 64'(first_ok + 1));
        chk("busy_at_done", busy, 0);
      end
      if (init_read && axi_start_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_cmd", 1, 0);
        end else begin
          c = exp_q.pop_front();
          chk("cmd_addr", axi_start_addr, c.a);
          chk("cmd_len", axi_byte_length, c.l);
        end
        chk("mo_limit", 64'(out_m < MO), 1);
        chk("busy_issue", busy, 1);
        if (consec && xfers > x0) chk("b2b_gap", 64'(cyc - last_cyc), 1);
        xfers++;
        last_cyc = cyc;
        out_m++;
      end else if (axi_idle) begin
        out_m = 0;
      end
      if (armed && first_ok == 0 && exp_q.size() == 0 && axi_idle &&
          cyc - last_cyc >= 2)
        first_ok = cyc;
    end
  end

  task automatic send(input logic [63:0] b, input logic [31:0] rb,
                      input logic [15:0] rows, input logic [31:0] st);
    int w;
    w = 0;
    desc_base = b;
    desc_row_bytes = rb;
    desc_rows = rows;
    desc_stride = st;
    desc_valid = 1'b1;
    @(negedge clk);
    while (!desc_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("desc_ready", desc_ready, 1);
    @(posedge clk);
    #1;
    desc_valid = 1'b0;
  endtask

  task automatic chk_reset();
    chk("rst_desc_ready", desc_ready, 0);
    chk("rst_init_read", init_read, 0);
    chk("rst_addr", axi_start_addr, 0);
    chk("rst_len", axi_byte_length, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cmd_count", cmd_count, 0);
  endtask

  // rmode: 0 ready high, 1 toggling, 2 random; imode: 0 idle high,
  // 1 idle low for 30 cycles, 2 random.
  task automatic run_desc(input logic [63:0] b, input logic [31:0] rb,
                          input logic [15:0] rows, input logic [31:0] st,
                          input int rmode, input int imode);
    int nd0;
    int i;
    expect_desc(b, rb, int'(rows), st);
    consec = (rmode == 0) && (imode == 0) && (exp_q.size() <= MO);
    nd0 = ndone;
    x0 = xfers;
    first_ok = 0;
    armed = 1'b1;
    if (imode == 1) axi_idle = 1'b0;
    send(b, rb, rows, st);
    i = 0;
    while (ndone == nd0 && i < 3000) begin
      if (rmode == 0) axi_start_ready = 1'b1;
      else if (rmode == 1) axi_start_ready = !axi_start_ready;
      else axi_start_ready = ($urandom_range(0, 3) != 0);
      if (imode == 1 && i == 30)
        chk("stall_cmds", 64'(xfers - x0), 64'((rows < MO) ? rows : MO));
      if (imode == 0) axi_idle = 1'b1;
      else if (imode == 1) axi_idle = (i >= 30);
      else axi_idle = ($urandom_range(0, 1) == 1);
      @(posedge clk);
      #1;
      i++;
    end
    chk("done_timeout", 64'(ndone != nd0), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", 64'(ndone - nd0), 1);
    chk("cmds_left", 64'(exp_q.size()), 0);
    chk("cmd_count", cmd_count, exp_total);
    chk("busy_after", busy, 0);
    armed = 1'b0;
    axi_start_ready = 1'b1;
    axi_idle = 1'b1;
  endtask

  task automatic err_desc(input logic [31:0] rb, input logic [15:0] rows);
    send(64'h4000, rb, rows, 32'd64);
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    chk("err_init", init_read, 0);
    @(posedge clk);
    #1;
    chk("err_single", err, 0);
    chk("err_no_cmd", init_read, 0);
    chk("err_count", cmd_count, exp_total);
  endtask

  initial begin
    logic [63:0] b;
    logic [31:0] rb, st;
    logic [15:0] rows;
    int i;

    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", desc_ready, 1);

    run_desc(64'h1000, 32'd256, 16'd4, 32'd1024, 0, 0);
    run_desc(64'h1000, 32'd256, 16'd4, 32'd1024, 1, 0);
    err_desc(32'd256, 16'd0);
    err_desc(32'd0, 16'd3);
    run_desc(64'h0, 32'd512, 16'd8, 32'd512, 0, 1);

    // Reset in the middle of a six-row descriptor.
    consec = 1'b0;
    expect_desc(64'h2000, 32'd64, 6, 32'd128);
    x0 = xfers;
    send(64'h2000, 32'd64, 16'd6, 32'd128);
    i = 0;
    while (xfers - x0 < 2 && i < 100) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("mid_rows_seen", 64'(xfers - x0 >= 2), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset();
    exp_q.delete();
    exp_total = '0;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_no_init", init_read, 0);
    end
    @(posedge clk);
    #1;
    run_desc(64'h1000, 32'd256, 16'd4, 32'd1024, 0, 0);

    run_desc(64'h0F80, 32'd256, 16'd1, 32'd0, 0, 0);
    run_desc(64'hFFFF_FFFF_FFFF_FF00, 32'd128, 16'd4, 32'h80, 2, 2);
    run_desc(64'h3000, 32'd64, 16'd3, 32'd0, 2, 2);
    run_desc(64'h5010, 32'd64, 16'd5, 32'd16, 2, 2);

    for (int k = 0; k < 8; k++) begin
      b = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) b[11:0] = 12'hF00 + 12'($urandom_range(0, 255));
      rb = $urandom_range(1, 9000);
      rows = 16'($urandom_range(1, 5));
      case ($urandom_range(0, 3))
        0: st = 32'd0;
        1: st = rb / 2;
        2: st = rb + 32'($urandom_range(0, 5000));
        default: st = $urandom;
      endcase
      run_desc(b, rb, rows, st, 2, 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
